// File: rtl/serial_mac_neuron_pkg.sv
// Shared types and constants for the serial MAC neuron.
// SERIAL_MAC_SAT_EN selects clamping (defined) or wrapping (undefined) of the ReLU result.
package serial_mac_neuron_pkg;

  localparam int DataWidth = 16;
  localparam int FracBits  = 8;
  localparam int AccWidth  = 2 * DataWidth + 6;
  localparam int CntrWidth = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Rescale the Q(2*FracBits) accumulator to Q(FracBits), apply ReLU, reduce to a data word.
  function automatic logic [DataWidth-1:0] relu_reduce(input logic signed [AccWidth-1:0] acc);
    logic signed [AccWidth-1:0] r;
    r = acc >>> FracBits;
    if (r[AccWidth-1]) begin
      return '0;
    end
`ifdef SERIAL_MAC_SAT_EN
    if (|r[AccWidth-2:DataWidth-1]) begin
      return {1'b0, {(DataWidth-1){1'b1}}};
    end else begin
      return r[DataWidth-1:0];
    end
`else
    return r[DataWidth-1:0];
`endif
  endfunction

endpackage

// File: rtl/serial_mac_neuron_if.sv
// Link between the neuron (master: drives word select and load) and the layer serializer.
interface serial_mac_neuron_if;
  import serial_mac_neuron_pkg::*;

  logic [CntrWidth-1:0] cntr;
  logic                 en;
  logic [DataWidth-1:0] l_in;

  modport master (output cntr, output en, input l_in);
  modport slave  (input cntr, input en, output l_in);

endinterface

// File: rtl/serial_mac_neuron_mac_unit.sv
// Signed multiply-accumulate register: load (bias + first product), add, or clear.
module mac_unit
  import serial_mac_neuron_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       add,
  input  logic                       clear,
  input  logic signed [DataWidth-1:0] a,
  input  logic signed [DataWidth-1:0] b,
  input  logic signed [DataWidth-1:0] bias,
  output logic signed [AccWidth-1:0]  acc_d,
  output logic signed [AccWidth-1:0]  acc_q
);

  logic signed [2*DataWidth-1:0] prod;
  logic signed [AccWidth-1:0]    prod_ext;
  logic signed [AccWidth-1:0]    bias_ext;

  assign prod     = a * b;
  assign prod_ext = {{(AccWidth-2*DataWidth){prod[2*DataWidth-1]}}, prod};
  // Bias is aligned to the product's 2*FracBits binary point.
  assign bias_ext = {{(AccWidth-DataWidth-FracBits){bias[DataWidth-1]}}, bias, {FracBits{1'b0}}};

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = bias_ext + prod_ext;
    end else if (add) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/serial_mac_neuron.sv
// One next-layer neuron: sequences a serializer pass, accumulates sum(x_k*w_k)+bias, emits ReLU result.
// Result width reduction clamps when SERIAL_MAC_SAT_EN is defined, otherwise wraps.
module serial_mac_neuron
  import serial_mac_neuron_pkg::*;
#(
  parameter int n_num = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  serial_mac_neuron_if.master         ser,
  input  logic [DataWidth*n_num-1:0]  weights,
  input  logic signed [DataWidth-1:0] bias,
  output logic                        busy,
  output logic [DataWidth-1:0]        neuron_out,
  output logic                        out_valid
);

  state_e                     state_q, state_d;
  logic [CntrWidth-1:0]       cntr_q, cntr_d;
  logic [DataWidth-1:0]       neuron_out_q, neuron_out_d;
  logic                       en;
  logic                       mac_load, mac_add, mac_clear, out_load;
  logic signed [AccWidth-1:0] acc_d, acc_q;
  logic [DataWidth-1:0]       w_arr [2**CntrWidth];
  logic signed [DataWidth-1:0] w_cur;

  genvar gi;
  generate
    for (gi = 0; gi < 2**CntrWidth; gi++) begin : g_wmux
      if (gi < n_num) begin : g_used
        assign w_arr[gi] = weights[gi*DataWidth +: DataWidth];
      end else begin : g_unused
        assign w_arr[gi] = '0;
      end
    end
  endgenerate

  assign w_cur = w_arr[cntr_q];

  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    en        = 1'b0;
    mac_load  = 1'b0;
    mac_add   = 1'b0;
    mac_clear = 1'b0;
    out_load  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          en       = 1'b1;
          mac_load = 1'b1;
          state_d  = ACC;
          cntr_d   = CntrWidth'(1);
        end else begin
          state_d   = IDLE;
          mac_clear = (state_q == DONE);
        end
      end
      ACC: begin
        mac_add = 1'b1;
        if (cntr_q == CntrWidth'(n_num - 1)) begin
          state_d  = DONE;
          cntr_d   = '0;
          out_load = 1'b1;
        end else begin
          cntr_d = cntr_q + CntrWidth'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cntr_d  = '0;
      end
    endcase
    // The serializer must never see a load while we are held in reset.
    if (!rst) begin
      en = 1'b0;
    end
  end

  always_comb begin
    neuron_out_d = neuron_out_q;
    if (out_load) begin
      neuron_out_d = relu_reduce(acc_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cntr_q       <= '0;
      neuron_out_q <= '0;
    end else begin
      state_q      <= state_d;
      cntr_q       <= cntr_d;
      neuron_out_q <= neuron_out_d;
    end
  end

  mac_unit u_mac (
    .clk   (clk),
    .rst   (rst),
    .load  (mac_load),
    .add   (mac_add),
    .clear (mac_clear),
    .a     (signed'(ser.l_in)),
    .b     (w_cur),
    .bias  (bias),
    .acc_d (acc_d),
    .acc_q (acc_q)
  );

  assign ser.cntr   = cntr_q;
  assign ser.en     = en;
  assign busy       = (state_q == ACC);
  assign out_valid  = (state_q == DONE);
  assign neuron_out = neuron_out_q;

endmodule
